// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive sides.
// State encoding is fixed so tx_state can be decoded on a logic analyser.
package uart_pkg;

    localparam int TX_STATE_W = 3;

    typedef enum logic [TX_STATE_W-1:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fsm_if.sv
// Byte-in / serial-out bundle of the UART transmitter.
// master = byte producer, slave = transmitter.
interface uart_tx_fsm_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8
);

    logic [DATA_BITS-1:0]  tx_data;
    logic                  tx_start;
    logic                  tx_serial;
    logic                  tx_busy;
    logic                  tx_done;
    logic                  tx_idle;
    logic [TX_STATE_W-1:0] tx_state;

    modport master (
        output tx_data,
        output tx_start,
        input  tx_serial,
        input  tx_busy,
        input  tx_done,
        input  tx_idle,
        input  tx_state
    );

    modport slave (
        input  tx_data,
        input  tx_start,
        output tx_serial,
        output tx_busy,
        output tx_done,
        output tx_idle,
        output tx_state
    );

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, bit_tick on the last cycle.
// clr restarts the period so a frame is aligned to its accept edge.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clka,
    input  logic reset_n,
    input  logic clr,
    output logic bit_tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clka or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bit_tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmitter: start, DATA_BITS data LSB first, [even parity], stop.
// Parity bit is enabled by defining UART_TX_PARITY_EN.
module uart_tx_fsm
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic          clka,
    input  logic          reset_n,
    uart_tx_fsm_if.slave  bus
);

    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    tx_state_e            state;
    logic [DATA_BITS-1:0] shift;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 accept;
    logic                 bit_tick;
`ifdef UART_TX_PARITY_EN
    logic                 par;
`endif

    assign accept = bus.tx_start && !bus.tx_busy;

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clka    (clka),
        .reset_n (reset_n),
        .clr     (accept),
        .bit_tick(bit_tick)
    );

    always_ff @(posedge clka or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            shift         <= '0;
            bit_cnt       <= '0;
            bus.tx_serial <= 1'b1;
            bus.tx_busy   <= 1'b0;
            bus.tx_done   <= 1'b0;
            bus.tx_idle   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par           <= 1'b0;
`endif
        end else begin
            bus.tx_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        shift       <= bus.tx_data;
                        bit_cnt     <= '0;
                        bus.tx_busy <= 1'b1;
                        bus.tx_idle <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        par         <= ^bus.tx_data;
`endif
                        state       <= START;
                    end
                end
                START: begin
                    if (bit_tick) state <= DATA;
                end
                DATA: begin
                    if (bit_tick) begin
                        shift <= shift >> 1;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            state   <= PARITY;
`else
                            state   <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end
                PARITY: begin
                    if (bit_tick) state <= STOP;
                end
                STOP: begin
                    if (bit_tick) begin
                        bus.tx_done <= 1'b1;
                        bus.tx_busy <= 1'b0;
                        bus.tx_idle <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Line follows the state one edge later, from a flop only.
            unique case (state)
                START:   bus.tx_serial <= 1'b0;
                DATA:    bus.tx_serial <= shift[0];
`ifdef UART_TX_PARITY_EN
                PARITY:  bus.tx_serial <= par;
`endif
                default: bus.tx_serial <= 1'b1;
            endcase
        end
    end

    assign bus.tx_state = state;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Scoreboard bench for uart_tx_fsm: stimulus queues frames and done times,
// a negedge monitor decodes the line and the done pulse against them.
module tb_uart_tx_fsm;

    localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * CPB;

    typedef struct {
        logic [7:0] data;
        int         acc;
    } frame_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    frame_t line_q[$];
    int     done_q[$];

    uart_tx_fsm_if #(.DATA_BITS(8)) bus ();

    uart_tx_fsm #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS(8)
    ) dut (
        .clka   (clk),
        .reset_n(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input bit ok, input string name,
                         input int act, input int exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (cyc %0d)",
                      name, act, exp, cyc);
    endtask

    function automatic logic exp_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
        if (b == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    // Monitor
    bit     in_frame = 0;
    int     s = 0;
    int     bad = 0;
    frame_t cur;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame = 0;
        end else begin
            if (!in_frame && bus.tx_serial === 1'b0) begin
                if (line_q.size() == 0) begin
                    check(0, "unexpected_start", cyc, -1);
                end else begin
                    cur = line_q.pop_front();
                    check(cyc == cur.acc + 1, "start_latency",
                          cyc, cur.acc + 1);
                    in_frame = 1;
                    s = 0;
                    bad = 0;
                end
            end
            if (in_frame) begin
                if (bus.tx_serial !== exp_bit(cur.data, s / CPB)) bad++;
                if (s % CPB == CPB - 1) begin
                    check(bad == 0,
                          $sformatf("bit%0d_data%02h_badsamples",
                                    s / CPB, cur.data),
                          bad, 0);
                    bad = 0;
                end
                s++;
                if (s == FRAME) in_frame = 0;
            end
            if (bus.tx_done === 1'b1) begin
                if (done_q.size() == 0) check(0, "unexpected_done", cyc, -1);
                else begin
                    int e;
                    e = done_q.pop_front();
                    check(cyc == e, "done_cycle", cyc, e);
                end
            end
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, output int acc);
        @(negedge clk);
        bus.tx_data  = d;
        bus.tx_start = 1'b1;
        acc = cyc + 1;
        line_q.push_back('{data: d, acc: acc});
        done_q.push_back(acc + FRAME);
        @(negedge clk);
        bus.tx_start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        int acc;
        int toggles;
        logic prev;

        bus.tx_data  = 8'h00;
        bus.tx_start = 1'b0;
        repeat (3) @(negedge clk);
        check(bus.tx_serial === 1'b1, "rst_serial", bus.tx_serial, 1);
        check(bus.tx_busy === 1'b0, "rst_busy", bus.tx_busy, 0);
        check(bus.tx_done === 1'b0, "rst_done", bus.tx_done, 0);
        check(bus.tx_idle === 1'b1, "rst_idle", bus.tx_idle, 1);
        check(bus.tx_state === 3'd0, "rst_state", bus.tx_state, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // T1 single frame
        send(8'hA5, acc);
        wait_cyc(acc + FRAME + 5);

        // T2 request while busy is ignored
        send(8'hA5, acc);
        wait_cyc(acc + 50);
        bus.tx_data  = 8'h3C;
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
        wait_cyc(acc + 2 * FRAME);
        check(line_q.size() == 0 && done_q.size() == 0, "t2_drain",
              line_q.size() + done_q.size(), 0);

        // T3 back-to-back with tx_start held
        @(negedge clk);
        bus.tx_data  = 8'h00;
        bus.tx_start = 1'b1;
        acc = cyc + 1;
        line_q.push_back('{data: 8'h00, acc: acc});
        done_q.push_back(acc + FRAME);
        @(negedge clk);
        bus.tx_data = 8'hFF;
        line_q.push_back('{data: 8'hFF, acc: acc + FRAME + 1});
        done_q.push_back(acc + 2 * FRAME + 1);
        wait_cyc(acc + FRAME + 1);
        bus.tx_start = 1'b0;
        wait_cyc(acc + 2 * FRAME + 10);
        check(line_q.size() == 0 && done_q.size() == 0, "t3_drain",
              line_q.size() + done_q.size(), 0);

        // T4 reset during data bit 3 (a 0 bit of A5)
        send(8'hA5, acc);
        wait_cyc(acc + 70);
        check(bus.tx_serial === 1'b0, "t4_pre_serial", bus.tx_serial, 0);
        #2;
        rst_n = 1'b0;
        line_q.delete();
        done_q.delete();
        #1;
        check(bus.tx_serial === 1'b1, "t4_serial", bus.tx_serial, 1);
        check(bus.tx_busy === 1'b0, "t4_busy", bus.tx_busy, 0);
        check(bus.tx_state === 3'd0, "t4_state", bus.tx_state, 0);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (FRAME) @(negedge clk);
        send(8'h5A, acc);
        wait_cyc(acc + FRAME + 5);

`ifdef UART_TX_PARITY_EN
        // T5 parity
        send(8'h07, acc);
        wait_cyc(acc + FRAME + 2);
        send(8'h03, acc);
        wait_cyc(acc + FRAME + 2);
`endif

        // T6 quiet line
        toggles = 0;
        prev = bus.tx_serial;
        repeat (1000) begin
            @(negedge clk);
            if (bus.tx_serial !== prev) toggles++;
            prev = bus.tx_serial;
        end
        check(toggles == 0, "t6_toggles", toggles, 0);
        check(bus.tx_serial === 1'b1, "t6_serial", bus.tx_serial, 1);
        check(bus.tx_idle === 1'b1, "t6_idle", bus.tx_idle, 1);
        check(bus.tx_busy === 1'b0, "t6_busy", bus.tx_busy, 0);
        check(line_q.size() == 0 && done_q.size() == 0, "final_drain",
              line_q.size() + done_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
